// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM: byte-enabled writes, 1- or 2-cycle read latency, selectable read-during-write.
// Define RAM_SDP_BE_PARITY_EN to add per-byte even parity with error injection and a rd_perr report.
module ram_sdp_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [ADDR_WIDTH-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wbe,
    input  logic                      re,
    input  logic [ADDR_WIDTH-1:0]     raddr,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      rvalid,
    input  logic                      perr_inject,
    output logic [DATA_WIDTH/8-1:0]   rd_perr
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $error("ram_sdp_be: RD_LATENCY must be 1 or 2");
        end
        if (DATA_WIDTH % 8 != 0) begin : g_bad_width
            $error("ram_sdp_be: DATA_WIDTH must be a multiple of 8");
        end
        if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw
            $error("ram_sdp_be: RDW_MODE must be 0 or 1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [DATA_WIDTH-1:0] rd_old;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [NB-1:0]         rd_err;
    logic                  rdw_hit;

    assign rdw_hit = we && (waddr == raddr);
    assign rd_old  = mem_data[raddr];

    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem_data[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Asynchronous array read happens before this edge's write lands, so
    // rd_old is the pre-write word; the bypass merges the incoming bytes.
    always_comb begin
        rd_word = rd_old;
        if (RDW_MODE == 1 && rdw_hit) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    rd_word[8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef RAM_SDP_BE_PARITY_EN
    logic [NB-1:0] mem_par [DEPTH];
    logic [NB-1:0] wr_par;
    logic [NB-1:0] rd_par_old;
    logic [NB-1:0] rd_par;

    always_comb begin
        wr_par = '0;
        for (int i = 0; i < NB; i++) begin
            wr_par[i] = (^wdata[8*i +: 8]) ^ perr_inject;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem_par[waddr][i] <= wr_par[i];
                end
            end
        end
    end

    assign rd_par_old = mem_par[raddr];

    // Bypassed bytes never saw storage, so they carry clean parity.
    always_comb begin
        rd_par = rd_par_old;
        if (RDW_MODE == 1 && rdw_hit) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    rd_par[i] = ^wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_err = '0;
        for (int i = 0; i < NB; i++) begin
            rd_err[i] = (^rd_word[8*i +: 8]) ^ rd_par[i];
        end
    end
`else
    logic unused_perr_inject;

    assign unused_perr_inject = perr_inject;
    assign rd_err             = '0;
`endif

    logic [DATA_WIDTH-1:0] s1_data;
    logic [NB-1:0]         s1_err;
    logic                  s1_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_err   <= '0;
        end else begin
            s1_valid <= re;
            if (re) begin
                s1_data <= rd_word;
            end
            s1_err <= re ? rd_err : '0;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rvalid  <= 1'b0;
                    rdata   <= '0;
                    rd_perr <= '0;
                end else begin
                    rvalid <= s1_valid;
                    if (s1_valid) begin
                        rdata <= s1_data;
                    end
                    rd_perr <= s1_valid ? s1_err : '0;
                end
            end
        end else begin : g_lat1
            assign rvalid  = s1_valid;
            assign rdata   = s1_data;
            assign rd_perr = s1_err;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sdp_be.sv
// Bench for ram_sdp_be: two instances (latency 1 / old-data RDW, latency 2 / bypass RDW)
// on shared stimulus, checked against a queue-based reference model every cycle.
module tb_ram_sdp_be;

    localparam int DW = 32;
    localparam int AW = 7;
    localparam int BW = DW / 8;
`ifdef RAM_SDP_BE_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, we, re, perr_inject;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] wbe;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          rvalid_a, rvalid_b;
    logic [BW-1:0] perr_a, perr_b;

    always #5 clk = ~clk;

    ram_sdp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .RDW_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re(re), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a),
        .perr_inject(perr_inject), .rd_perr(perr_a)
    );

    ram_sdp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .RDW_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re(re), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b),
        .perr_inject(perr_inject), .rd_perr(perr_b)
    );

    // Reference model: word array, per-byte "stored with bad parity" flags,
    // and per-instance queues of reads stamped with the edge they emerge on.
    typedef struct {
        int            due;
        logic [DW-1:0] d;
        logic [BW-1:0] e;
    } pend_t;

    logic [DW-1:0] mm [2**AW];
    logic [BW-1:0] me [2**AW];
    pend_t         qa[$];
    pend_t         qb[$];
    logic          ev_a, ev_b;
    logic [DW-1:0] ed_a, ed_b;
    logic [BW-1:0] ep_a, ep_b;
    int            edge_n = 0;
    int            errors = 0;
    int            checks = 0;

    typedef struct {
        logic          wr;
        logic          same;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [BW-1:0] be;
        logic [AW-1:0] ra;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        string         nm;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [DW-1:0] oldw, neww;
        logic [BW-1:0] olde, newe;
        pend_t         p;
        edge_n++;
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            ev_a = 1'b0; ev_b = 1'b0;
            ed_a = '0;   ed_b = '0;
            ep_a = '0;   ep_b = '0;
            return;
        end
        if (re) begin
            oldw = mm[raddr];
            olde = PAR ? me[raddr] : '0;
            neww = oldw;
            newe = olde;
            if (we && waddr == raddr) begin
                for (int i = 0; i < BW; i++) begin
                    if (wbe[i]) begin
                        neww[8*i +: 8] = wdata[8*i +: 8];
                        newe[i] = 1'b0;
                    end
                end
            end
            p.due = edge_n;     p.d = oldw; p.e = olde; qa.push_back(p);
            p.due = edge_n + 1; p.d = neww; p.e = newe; qb.push_back(p);
        end
        if (we) begin
            for (int i = 0; i < BW; i++) begin
                if (wbe[i]) begin
                    mm[waddr][8*i +: 8] = wdata[8*i +: 8];
                    me[waddr][i] = perr_inject;
                end
            end
        end
        ev_a = 1'b0; ep_a = '0;
        ev_b = 1'b0; ep_b = '0;
        if (qa.size() > 0 && qa[0].due == edge_n) begin
            p = qa.pop_front();
            ev_a = 1'b1; ed_a = p.d; ep_a = p.e;
        end
        if (qb.size() > 0 && qb[0].due == edge_n) begin
            p = qb.pop_front();
            ev_b = 1'b1; ed_b = p.d; ep_b = p.e;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("model_rvalid_a", 32'(rvalid_a), 32'(ev_a));
        chk("model_rdata_a",  rdata_a,       ed_a);
        chk("model_perr_a",   32'(perr_a),   32'(ep_a));
        chk("model_rvalid_b", 32'(rvalid_b), 32'(ev_b));
        chk("model_rdata_b",  rdata_b,       ed_b);
        chk("model_perr_b",   32'(perr_b),   32'(ep_b));
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] be, input logic inj);
        we = 1'b1; waddr = a; wdata = d; wbe = be; perr_inject = inj;
        tick();
        we = 1'b0; perr_inject = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; re = 1'b1; raddr = '0; waddr = '0;
        wdata = '0; wbe = '0; perr_inject = 1'b0;

        for (int k = 0; k < 2; k++) begin
            tick();
            chk("reset_rvalid_a", 32'(rvalid_a), 32'd0);
            chk("reset_rdata_a",  rdata_a,       32'd0);
            chk("reset_rvalid_b", 32'(rvalid_b), 32'd0);
            chk("reset_rdata_b",  rdata_b,       32'd0);
            chk("reset_perr_b",   32'(perr_b),   32'd0);
        end
        rst_n = 1'b1; re = 1'b0;
        tick();

        vecs[0] = '{1'b1, 1'b0, 7'h05, 32'hDEADBEEF, 4'hF, 7'h05, 32'hDEADBEEF, 32'hDEADBEEF, "basic"};
        vecs[1] = '{1'b1, 1'b0, 7'h10, 32'h11223344, 4'hF, 7'h10, 32'h11223344, 32'h11223344, "be_full"};
        vecs[2] = '{1'b1, 1'b0, 7'h10, 32'hAABBCCDD, 4'h5, 7'h10, 32'h11BB33DD, 32'h11BB33DD, "be_0101"};
        vecs[3] = '{1'b1, 1'b0, 7'h20, 32'h00000001, 4'hF, 7'h20, 32'h00000001, 32'h00000001, "rdw_pre"};
        vecs[4] = '{1'b1, 1'b1, 7'h20, 32'h000000FF, 4'h1, 7'h20, 32'h00000001, 32'h000000FF, "rdw_same"};
        vecs[5] = '{1'b0, 1'b0, 7'h00, 32'h00000000, 4'h0, 7'h20, 32'h000000FF, 32'h000000FF, "rdw_after"};
        vecs[6] = '{1'b1, 1'b1, 7'h21, 32'h12345678, 4'hF, 7'h20, 32'h000000FF, 32'h000000FF, "rdw_diff"};
        vecs[7] = '{1'b1, 1'b0, 7'h20, 32'hFFFFFFFF, 4'h0, 7'h20, 32'h000000FF, 32'h000000FF, "wbe_zero"};

        for (int k = 0; k < NV; k++) begin
            if (vecs[k].wr) begin
                we = 1'b1; waddr = vecs[k].wa; wdata = vecs[k].wd; wbe = vecs[k].be;
            end
            if (vecs[k].wr && !vecs[k].same) begin
                tick();
                we = 1'b0;
            end
            re = 1'b1; raddr = vecs[k].ra;
            tick();
            we = 1'b0; re = 1'b0;
            chk({vecs[k].nm, "_rdata_a"},  rdata_a,        vecs[k].exp_a);
            chk({vecs[k].nm, "_rvalid_a"}, 32'(rvalid_a),  32'd1);
            chk({vecs[k].nm, "_early_b"},  32'(rvalid_b),  32'd0);
            tick();
            chk({vecs[k].nm, "_rdata_b"},  rdata_b,        vecs[k].exp_b);
            chk({vecs[k].nm, "_rvalid_b"}, 32'(rvalid_b),  32'd1);
            chk({vecs[k].nm, "_late_a"},   32'(rvalid_a),  32'd0);
        end

        for (int a = 0; a < 8; a++) write(AW'(a), DW'(a * 3), 4'hF, 1'b0);
        for (int a = 0; a < 9; a++) begin
            raddr = AW'(a);
            re = (a < 8);
            tick();
            if (a < 8) begin
                chk("stream_rdata_a",  rdata_a,       32'(a * 3));
                chk("stream_rvalid_a", 32'(rvalid_a), 32'd1);
            end
            if (a > 0) begin
                chk("stream_rdata_b",  rdata_b,       32'((a - 1) * 3));
                chk("stream_rvalid_b", 32'(rvalid_b), 32'd1);
            end
        end
        re = 1'b0;
        tick();

        re = 1'b1; raddr = 7'h07;
        tick();
        re = 1'b0; rst_n = 1'b0;
        tick();
        chk("midrst_rvalid_b", 32'(rvalid_b), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("midrst_drop_b", 32'(rvalid_b), 32'd0);
        end
        re = 1'b1; raddr = 7'h07;
        tick();
        re = 1'b0;
        chk("midrst_keep_a", rdata_a, 32'd21);
        tick();
        chk("midrst_keep_b", rdata_b, 32'd21);

        write(7'h30, 32'hA5A5A5A5, 4'hF, 1'b0);
        write(7'h30, 32'hA5A5A5A5, 4'b0010, 1'b1);
        re = 1'b1; raddr = 7'h30;
        tick();
        re = 1'b0;
        chk("par_rdata_a", rdata_a,     32'hA5A5A5A5);
        chk("par_perr_a",  32'(perr_a), PAR ? 32'h2 : 32'h0);
        tick();
        chk("par_perr_b",  32'(perr_b), PAR ? 32'h2 : 32'h0);
        write(7'h30, 32'hA5A5A5A5, 4'hF, 1'b0);
        re = 1'b1; raddr = 7'h30;
        tick();
        re = 1'b0;
        chk("par_clean_a", 32'(perr_a), 32'd0);
        tick();
        chk("par_clean_b", 32'(perr_b), 32'd0);

        for (int a = 0; a < 16; a++) write(AW'(a), DW'($urandom), 4'hF, 1'b0);
        for (int n = 0; n < 400; n++) begin
            rst_n       = ($urandom_range(0, 49) != 0);
            we          = 1'($urandom);
            re          = 1'($urandom);
            waddr       = AW'($urandom_range(0, 15));
            raddr       = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, 15));
            wdata       = DW'($urandom);
            wbe         = BW'($urandom);
            perr_inject = ($urandom_range(0, 3) == 0);
            tick();
        end
        rst_n = 1'b1; we = 1'b0; re = 1'b0; perr_inject = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
